// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline stall/flush sequencer:
//   - state_t      : FSM state encoding (RUN / MDWAIT / MDREL)
//   - ctrl_t       : packed pipeline-control bundle
//                    {pc_write, if_id_write, if_id_flush, ctrl_mux}
//   - CTRL_*       : control patterns for normal flow, stall, flush and reset
//   - MD_CYCLES_DEFAULT : default MUL/DIV latency (issue cycle included)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MDWAIT = 2'd1,
    MDREL  = 2'd2
  } state_t;

  localparam int MD_CYCLES_DEFAULT = 4;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic ctrl_mux;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = 4'b1100;  // PC and IF/ID advance
  localparam ctrl_t CTRL_STALL   = 4'b0001;  // hold PC and IF/ID, bubble ID/EX
  localparam ctrl_t CTRL_FLUSH   = 4'b1111;  // redirect, NOP into IF/ID, bubble ID/EX
  localparam ctrl_t CTRL_RESET   = 4'b0011;  // frozen front end, everything squashed

endpackage

// File: rtl/md_latency_counter.sv
// md_latency_counter
//   Down-counter timing the in-flight MUL/DIV operation.
//   Ports:
//     clk, rst : clock, synchronous active-high reset (clears the count)
//     load     : load MD_CYCLES-1 (issue cycle of a MUL/DIV)
//     dec      : decrement by one (saturates at zero)
//     clr      : clear to zero (abort by branch)
//     last     : count is 1, i.e. this is the final MDWAIT cycle
module md_latency_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT,
  parameter int CNT_W     = $clog2(MD_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  input  logic clr,
  output logic last
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= LOAD_VAL;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign last = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. Merges load-use stalls,
//   taken-branch flushes and fixed-latency MUL/DIV stalls in one FSM.
//   All control outputs are combinational from state and inputs so a hazard
//   stalls the pipeline in the cycle it is detected.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     ldHazard    : load-use hazard this cycle
//     mdReq       : instruction in ID is MUL/DIV
//     branchTaken : branch in EX resolved taken
//     PCwrite, IF_ID_write, IF_ID_flush, ctrlMux : pipeline controls
//     mdStart     : one-cycle launch pulse for the MUL/DIV unit
//     mdBusy      : sequencer is outside RUN
//     stallCount  : saturating stall-cycle counter (only when the
//                   STALL_COUNTER_EN macro is defined)
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT,  // legal range 2..15
  parameter int CNT_W     = $clog2(MD_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ldHazard,
  input  logic        mdReq,
  input  logic        branchTaken,
  output logic        PCwrite,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ctrlMux,
  output logic        mdStart,
  output logic        mdBusy
`ifdef STALL_COUNTER_EN
  ,
  output logic [15:0] stallCount
`endif
);

  state_t state_reg, state_next;
  ctrl_t  ctrl;
  logic   md_start;
  logic   cnt_load, cnt_dec, cnt_clr, cnt_last;

  md_latency_counter #(
    .MD_CYCLES (MD_CYCLES),
    .CNT_W     (CNT_W)
  ) u_md_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .clr  (cnt_clr),
    .last (cnt_last)
  );

  always_comb begin
    ctrl       = CTRL_DEFAULT;
    md_start   = 1'b0;
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_clr    = 1'b0;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state_reg)
        RUN: begin
          // A taken branch squashes the ID instruction, so its hazards are moot.
          if (branchTaken) begin
            ctrl = CTRL_FLUSH;
          end else if (ldHazard) begin
            ctrl = CTRL_STALL;
          end else if (mdReq) begin
            ctrl       = CTRL_STALL;
            md_start   = 1'b1;
            cnt_load   = 1'b1;
            state_next = MDWAIT;
          end
        end
        MDWAIT: begin
          if (branchTaken) begin
            ctrl       = CTRL_FLUSH;
            cnt_clr    = 1'b1;
            state_next = RUN;
          end else begin
            ctrl    = CTRL_STALL;
            cnt_dec = 1'b1;
            if (cnt_last) begin
              state_next = MDREL;
            end
          end
        end
        MDREL: begin
          // The issuing MUL/DIV is still in ID here; its mdReq must not re-fire.
          if (branchTaken) begin
            ctrl    = CTRL_FLUSH;
            cnt_clr = 1'b1;
          end
          state_next = RUN;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  assign PCwrite     = ctrl.pc_write;
  assign IF_ID_write = ctrl.if_id_write;
  assign IF_ID_flush = ctrl.if_id_flush;
  assign ctrlMux     = ctrl.ctrl_mux;
  assign mdStart     = md_start;
  assign mdBusy      = !rst && (state_reg != RUN);

`ifdef STALL_COUNTER_EN
  logic [15:0] stall_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_reg <= '0;
    end else if (!ctrl.pc_write && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign stallCount = stall_count_reg;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl
//   Directed and randomized stimulus against a reference model that tracks
//   "stall cycles still owed" and "release cycle pending" rather than FSM states.
module tb_pipeline_stall_ctrl;

  localparam int MD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld  = 1'b0;
  logic md  = 1'b0;
  logic br  = 1'b0;

  logic pc_write, if_id_write, if_id_flush, ctrl_mux, md_start, md_busy;
`ifdef STALL_COUNTER_EN
  logic [15:0] stall_count;
`endif

  pipeline_stall_ctrl #(.MD_CYCLES(MD)) dut (
    .clk         (clk),
    .rst         (rst),
    .ldHazard    (ld),
    .mdReq       (md),
    .branchTaken (br),
    .PCwrite     (pc_write),
    .IF_ID_write (if_id_write),
    .IF_ID_flush (if_id_flush),
    .ctrlMux     (ctrl_mux),
    .mdStart     (md_start),
    .mdBusy      (md_busy)
`ifdef STALL_COUNTER_EN
    ,
    .stallCount  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int md_left = 0;   // MUL/DIV wait cycles still owed after the issue cycle
  bit rel     = 0;   // release cycle due next
  int sc      = 0;   // expected stall counter

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, compare, advance model.
  // Control vector order: {PCwrite, IF_ID_write, IF_ID_flush, ctrlMux, mdStart, mdBusy}
  task automatic step(input bit r, input bit l, input bit m, input bit b, input bit verbose);
    logic [5:0] exp_v;
    logic [5:0] act_v;
    bit busy;
    @(posedge clk);
    #1;
    rst = r; ld = l; md = m; br = b;
    busy = (md_left > 0) || rel;
    if (r)                exp_v = 6'b001100;
    else if (b)           exp_v = {5'b11110, busy};
    else if (md_left > 0) exp_v = 6'b000101;
    else if (rel)         exp_v = 6'b110001;
    else if (l)           exp_v = 6'b000100;
    else if (m)           exp_v = 6'b000110;
    else                  exp_v = 6'b110000;
    @(negedge clk);
    act_v = {pc_write, if_id_write, if_id_flush, ctrl_mux, md_start, md_busy};
    check_val("ctl", {26'd0, act_v}, {26'd0, exp_v});
`ifdef STALL_COUNTER_EN
    check_val("stall_count", {16'd0, stall_count}, sc);
`endif
    if (verbose)
      $display("cyc rst=%0b ld=%0b md=%0b br=%0b -> ctl=%06b exp=%06b", r, l, m, b, act_v, exp_v);
    // Advance model to the state after the coming edge
    if (r) sc = 0;
    else if (!exp_v[5] && sc < 65535) sc++;
    if (r || b) begin
      md_left = 0; rel = 0;
    end else if (md_left > 0) begin
      md_left--;
      if (md_left == 0) rel = 1;
    end else if (rel) begin
      rel = 0;
    end else if (!l && m) begin
      md_left = MD - 1;
    end
  endtask

  initial begin
    // Reset with all inputs high, then release with inputs low
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    // Load-use single stall
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // MUL/DIV with mdReq held: issue, 3 waits, release, then re-issue
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    // All hazards with branch in RUN
    step(0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    // Abort in the second MDWAIT cycle, then a fresh issue
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    // Reset mid-MDWAIT
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 1);
    end
`ifdef STALL_COUNTER_EN
    // Saturation: sustained load-use stalls past the counter limit
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 65540; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check_val("stall_sat", {16'd0, stall_count}, 32'h0000FFFF);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
